pcs_lane_deskew: RTL and testbench
==================================

PCS_LANE_DESKEW -- requirements
Module: pcs_lane_deskew

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, range 1..8: number of receive lanes.
REQ-002 SHALL have parameter DEPTH, default 8, power of 2 in 4..16: per-lane FIFO entries.
REQ-003 SHALL have parameter MAX_SKEW, default 6, range 1..DEPTH-2: max tolerated inter-lane skew in cycles.
REQ-004 SHALL have ports: PCLK  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have ports: RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: Deskew_En  in  1  enable; low flushes FIFOs and holds the FSM in SEARCH.
REQ-007 SHALL have ports: Lane_Data  in  8*NUM_LANES  decoded symbols, lane i at bits [8i+7:8i].
REQ-008 SHALL have ports: Lane_DataK  in  NUM_LANES  K-flag per lane.
REQ-009 SHALL have ports: Lane_Valid  in  NUM_LANES  per-lane write strobe.
REQ-010 SHALL have ports: Deskew_Data  out  8*NUM_LANES  aligned symbols, registered.
REQ-011 SHALL have ports: Deskew_DataK  out  NUM_LANES  aligned K-flags, registered.
REQ-012 SHALL have ports: Deskew_Valid  out  1  aligned word valid, registered.
REQ-013 SHALL have ports: Deskewed  out  1  high while FSM is ALIGNED.
REQ-014 SHALL have ports: Skew_Err  out  1  one-cycle error pulse.
REQ-015 SHALL have ports: Skew_Value  out  $clog2(DEPTH)+1  measured skew, latched on alignment.

Function
REQ-016 COM SHALL be the symbol 8'hBC with K=1 (K28.5).
REQ-017 Each lane SHALL write its FIFO in every cycle its Lane_Valid is high and Deskew_En is high.
REQ-018 Full SHALL mean count==DEPTH; a write at full with no read in the same cycle is an overflow; write+read at full SHALL be legal.
REQ-019 FSM states SHALL be SEARCH, WAIT_ALL, ALIGNED; reset state SEARCH.
REQ-020 SEARCH: each non-empty lane whose head is not COM SHALL pop one entry per cycle (discard); a lane whose head is COM SHALL hold.
REQ-021 SEARCH -> WAIT_ALL SHALL occur when the first lane holds COM at head; a skew counter SHALL start at 0 that cycle.
REQ-022 WAIT_ALL: the skew counter SHALL increment each cycle, other lanes keep discarding; when all lanes hold COM, SHALL go to ALIGNED and latch Skew_Value = counter.
REQ-023 If the counter exceeds MAX_SKEW in WAIT_ALL, SHALL pulse Skew_Err, flush all FIFOs, return to SEARCH.
REQ-024 COM at head on all lanes in the same cycle in SEARCH SHALL go straight to ALIGNED with Skew_Value = 0.
REQ-025 ALIGNED: when all lanes are non-empty, all SHALL pop together and the next cycle SHALL present the word with Deskew_Valid=1; if any lane is empty, no lane pops and Deskew_Valid=0 next cycle.
REQ-026 ALIGNED: a popped word with COM on some but not all lanes SHALL pulse Skew_Err, flush, return to SEARCH; that word SHALL not be presented valid.
REQ-027 Overflow on any lane in any state SHALL pulse Skew_Err, flush, return to SEARCH.
REQ-028 Minimum latency SHALL be 2 cycles: written in cycle t, popped t+1, on outputs t+2.
REQ-029 Deskew_Data/DataK SHALL hold their last value when Deskew_Valid=0.
REQ-030 Deskew_En low SHALL take priority over all events: flush, SEARCH, Deskew_Valid=0, no Skew_Err.
REQ-031 Flush SHALL clear pointers and counts in one cycle; writes in the flush cycle are dropped.
REQ-032 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 RST high at a PCLK edge SHALL set: FSM SEARCH, FIFOs empty, Deskew_Data=0, Deskew_DataK=0, Deskew_Valid=0, Deskewed=0, Skew_Err=0, Skew_Value=0.
REQ-034 RST SHALL override Deskew_En and all in-flight operations, including mid-ALIGNED.

Verification
REQ-035 4 lanes, COM on all lanes same cycle then D-symbols 0x01.. -> ALIGNED, Skew_Value=0, first valid word all 0xBC/K=1 two cycles after the COM write.
REQ-036 Lane delays 0,1,3,2 cycles -> Skew_Value=3, output lanes carry identical sequences, Deskewed=1.
REQ-037 Lane 3 delayed 7 cycles (MAX_SKEW=6) -> Skew_Err one cycle, FIFOs flushed, FSM SEARCH, re-aligns on next COM set.
REQ-038 Aligned; lane 2 Lane_Valid held low 2 cycles -> Deskew_Valid=0 for those cycles, no data loss, no Skew_Err.
REQ-039 Aligned; inject lone COM on lane 1 -> Skew_Err pulse, Deskewed drops next cycle.
REQ-040 RST asserted mid-ALIGNED, and Deskew_En dropped mid-WAIT_ALL -> all outputs at reset values / SEARCH with no Skew_Err.

Source files
------------

// File: rtl/pcs_lane_deskew.sv
// ---------------------------------------------------------------------------
// pcs_lane_deskew
//   Multi-lane PCS deskew. Each receive lane feeds a small FIFO; the aligner
//   discards symbols until every lane presents COM (K28.5) at its FIFO head,
//   then pops all lanes in lock-step so the output word is lane-aligned.
//   Inter-lane skew is measured while waiting for the last COM and reported
//   on alignment. Excess skew, FIFO overflow or a partial COM column while
//   aligned flush everything and restart the search.
//
// Ports
//   PCLK          single rising-edge clock
//   RST           synchronous active-high reset
//   Deskew_En     enable; low flushes the FIFOs and holds the FSM in SEARCH
//   Lane_Data     received symbols, lane i at [8i+7:8i]
//   Lane_DataK    K-flag per lane
//   Lane_Valid    per-lane write strobe
//   Deskew_Data   aligned symbols (registered, held when not valid)
//   Deskew_DataK  aligned K-flags (registered, held when not valid)
//   Deskew_Valid  aligned word valid (registered)
//   Deskewed      high while the FSM is ALIGNED (registered)
//   Skew_Err      one-cycle error pulse (registered)
//   Skew_Value    measured skew in cycles, latched on alignment
// ---------------------------------------------------------------------------
module pcs_lane_deskew #(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned MAX_SKEW  = 6
) (
   input  logic                       PCLK,
   input  logic                       RST,
   input  logic                       Deskew_En,
   input  logic [8*NUM_LANES-1:0]     Lane_Data,
   input  logic [NUM_LANES-1:0]       Lane_DataK,
   input  logic [NUM_LANES-1:0]       Lane_Valid,
   output logic [8*NUM_LANES-1:0]     Deskew_Data,
   output logic [NUM_LANES-1:0]       Deskew_DataK,
   output logic                       Deskew_Valid,
   output logic                       Deskewed,
   output logic                       Skew_Err,
   output logic [$clog2(DEPTH):0]     Skew_Value
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [7:0]  COM_SYM = 8'hBC;

   typedef struct packed {
      logic       k;
      logic [7:0] d;
   } sym_t;

   typedef enum logic [1:0] {
      SEARCH   = 2'd0,
      WAIT_ALL = 2'd1,
      ALIGNED  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Per-lane FIFO storage and bookkeeping
   sym_t                         mem [NUM_LANES][DEPTH];
   logic [NUM_LANES-1:0][AW-1:0] wr_ptr;
   logic [NUM_LANES-1:0][AW-1:0] rd_ptr;
   logic [NUM_LANES-1:0][CW-1:0] count;

   // Head-of-FIFO view
   sym_t [NUM_LANES-1:0]         head;
   logic [NUM_LANES-1:0]         nonempty;
   logic [NUM_LANES-1:0]         full;
   logic [NUM_LANES-1:0]         head_com;
   logic                         all_com;
   logic                         any_com;
   logic                         all_ne;

   // Control
   logic [CW-1:0]                skew_cnt, skew_cnt_nxt;
   logic [NUM_LANES-1:0]         pop_c;
   logic [NUM_LANES-1:0]         overflow_c;
   logic                         word_ok_c;
   logic                         latch_c;
   logic [CW-1:0]                skew_lat_c;
   logic                         timeout_c;
   logic                         misalign_c;
   logic                         err_c;
   logic                         flush_c;

   // Head symbol and occupancy flags per lane
   always_comb begin
      head     = '0;
      nonempty = '0;
      full     = '0;
      head_com = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         head[i]     = mem[i][rd_ptr[i]];
         nonempty[i] = (count[i] != '0);
         full[i]     = (count[i] == CW'(DEPTH));
         head_com[i] = nonempty[i] && head[i].k && (head[i].d == COM_SYM);
      end
   end

   assign all_com = &head_com;
   assign any_com = |head_com;
   assign all_ne  = &nonempty;

   // FSM state register
   always_ff @(posedge PCLK) begin
      if (RST) begin
         state    <= SEARCH;
         skew_cnt <= '0;
      end else begin
         state    <= state_nxt;
         skew_cnt <= skew_cnt_nxt;
      end
   end

   // Next state, pop control and error detection.
   // skew_cnt holds the number of cycles since the first lane showed COM,
   // so it reads 1 in the first WAIT_ALL cycle.
   // The column that completes alignment is popped in the same cycle, which
   // gives the two-cycle write-to-output latency.
   always_comb begin
      state_nxt    = state;
      skew_cnt_nxt = skew_cnt;
      pop_c        = '0;
      word_ok_c    = 1'b0;
      latch_c      = 1'b0;
      skew_lat_c   = '0;
      timeout_c    = 1'b0;
      misalign_c   = 1'b0;

      case (state)
         SEARCH: begin
            if (all_com) begin
               pop_c      = '1;
               word_ok_c  = 1'b1;
               latch_c    = 1'b1;
               skew_lat_c = '0;
               state_nxt  = ALIGNED;
            end else begin
               pop_c = nonempty & ~head_com;
               if (any_com) begin
                  state_nxt    = WAIT_ALL;
                  skew_cnt_nxt = CW'(1);
               end
            end
         end
         WAIT_ALL: begin
            if (skew_cnt > CW'(MAX_SKEW)) begin
               timeout_c = 1'b1;
            end else if (all_com) begin
               pop_c      = '1;
               word_ok_c  = 1'b1;
               latch_c    = 1'b1;
               skew_lat_c = skew_cnt;
               state_nxt  = ALIGNED;
            end else begin
               pop_c        = nonempty & ~head_com;
               skew_cnt_nxt = skew_cnt + CW'(1);
            end
         end
         ALIGNED: begin
            if (all_ne) begin
               pop_c = '1;
               // A partial COM column means the lanes have slipped
               if (any_com && !all_com) begin
                  misalign_c = 1'b1;
               end else begin
                  word_ok_c = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = SEARCH;
         end
      endcase

      // Write at full is only an overflow when the same lane does not pop
      overflow_c = Lane_Valid & full & ~pop_c;
      err_c      = Deskew_En && ((|overflow_c) || timeout_c || misalign_c);
      flush_c    = !Deskew_En || err_c;

      if (flush_c) begin
         state_nxt = SEARCH;
         word_ok_c = 1'b0;
         latch_c   = 1'b0;
      end
   end

   // FIFO pointers and counts; a flush clears them and drops same-cycle writes
   always_ff @(posedge PCLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (flush_c) begin
               wr_ptr[i] <= '0;
               rd_ptr[i] <= '0;
               count[i]  <= '0;
            end else begin
               if (Lane_Valid[i]) begin
                  wr_ptr[i] <= wr_ptr[i] + AW'(1);
               end
               if (pop_c[i]) begin
                  rd_ptr[i] <= rd_ptr[i] + AW'(1);
               end
               count[i] <= count[i] + CW'(Lane_Valid[i]) - CW'(pop_c[i]);
            end
         end
      end
   end

   // FIFO storage write port
   always_ff @(posedge PCLK) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (!flush_c && Lane_Valid[i]) begin
            mem[i][wr_ptr[i]] <= sym_t'({Lane_DataK[i], Lane_Data[8*i +: 8]});
         end
      end
   end

   // Registered outputs; data holds its last value between valid words
   always_ff @(posedge PCLK) begin
      if (RST) begin
         Deskew_Data  <= '0;
         Deskew_DataK <= '0;
         Deskew_Valid <= 1'b0;
         Deskewed     <= 1'b0;
         Skew_Err     <= 1'b0;
         Skew_Value   <= '0;
      end else begin
         Deskew_Valid <= word_ok_c;
         Deskewed     <= (state_nxt == ALIGNED);
         Skew_Err     <= err_c;
         if (latch_c) begin
            Skew_Value <= skew_lat_c;
         end
         if (word_ok_c) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               Deskew_Data[8*i +: 8] <= head[i].d;
               Deskew_DataK[i]       <= head[i].k;
            end
         end
      end
   end

endmodule

// File: tb/tb_pcs_lane_deskew.sv
// ---------------------------------------------------------------------------
// tb_pcs_lane_deskew
//   Directed bench for pcs_lane_deskew (4 lanes, DEPTH 8, MAX_SKEW 6).
//   Each lane carries junk D-symbols, then COM, then D-symbols 0x01, 0x02...
//   delayed per lane by dly[i] cycles. Inputs change on the falling edge and
//   outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_pcs_lane_deskew;

   logic        PCLK = 1'b0;
   logic        RST;
   logic        Deskew_En;
   logic [31:0] Lane_Data;
   logic [3:0]  Lane_DataK;
   logic [3:0]  Lane_Valid;
   logic [31:0] Deskew_Data;
   logic [3:0]  Deskew_DataK;
   logic        Deskew_Valid;
   logic        Deskewed;
   logic        Skew_Err;
   logic [3:0]  Skew_Value;

   int checks = 0;
   int errors = 0;
   int dly [4];

   always #5 PCLK = ~PCLK;

   pcs_lane_deskew #(
      .NUM_LANES (4),
      .DEPTH     (8),
      .MAX_SKEW  (6)
   ) dut (
      .PCLK         (PCLK),
      .RST          (RST),
      .Deskew_En    (Deskew_En),
      .Lane_Data    (Lane_Data),
      .Lane_DataK   (Lane_DataK),
      .Lane_Valid   (Lane_Valid),
      .Deskew_Data  (Deskew_Data),
      .Deskew_DataK (Deskew_DataK),
      .Deskew_Valid (Deskew_Valid),
      .Deskewed     (Deskewed),
      .Skew_Err     (Skew_Err),
      .Skew_Value   (Skew_Value)
   );

   // Sequence symbol n of a lane: n<0 junk, n==0 COM, else D-symbol n
   function automatic logic [8:0] lane_sym(input int n);
      if (n < 0)  return {1'b0, 8'h55};
      if (n == 0) return {1'b1, 8'hBC};
      return {1'b0, 8'(n)};
   endfunction

   function automatic logic [31:0] exp_word(input int n);
      logic [8:0] s;
      s = lane_sym(n);
      return {4{s[7:0]}};
   endfunction

   function automatic logic [3:0] exp_k(input int n);
      logic [8:0] s;
      s = lane_sym(n);
      return {4{s[8]}};
   endfunction

   task automatic tick();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   // Drive cycle c of the per-lane delayed streams
   task automatic set_lanes(input int c);
      logic [8:0] s;
      for (int i = 0; i < 4; i++) begin
         s = lane_sym(c - dly[i]);
         Lane_Data[8*i +: 8] = s[7:0];
         Lane_DataK[i]       = s[8];
      end
      Lane_Valid = 4'hF;
      Deskew_En  = 1'b1;
      RST        = 1'b0;
   endtask

   task automatic flush_idle();
      RST        = 1'b0;
      Deskew_En  = 1'b0;
      Lane_Valid = 4'h0;
      tick();
   endtask

   task automatic test_reset();
      RST        = 1'b1;
      Deskew_En  = 1'b1;
      Lane_Valid = 4'hF;
      Lane_Data  = 32'hBCBC_BCBC;
      Lane_DataK = 4'hF;
      tick();
      tick();
      checks++;
      if ({Deskew_Valid, Deskewed, Skew_Err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b expected 000", {Deskew_Valid, Deskewed, Skew_Err});
      end
      checks++;
      if (Deskew_Data !== 32'h0 || Deskew_DataK !== 4'h0) begin
         errors++;
         $display("FAIL reset_data got %h/%h expected 00000000/0", Deskew_Data, Deskew_DataK);
      end
      checks++;
      if (Skew_Value !== 4'd0) begin
         errors++;
         $display("FAIL reset_skew got %0d expected 0", Skew_Value);
      end
      Lane_Valid = 4'h0;
      RST        = 1'b0;
      tick();
   endtask

   task automatic test_same_cycle();
      int n;
      n = 0;
      flush_idle();
      dly = '{0, 0, 0, 0};
      for (int c = 0; c < 10; c++) begin
         set_lanes(c);
         tick();
         if (c == 0) begin
            checks++;
            if (Deskew_Valid !== 1'b0) begin
               errors++;
               $display("FAIL same_early_valid got %b expected 0", Deskew_Valid);
            end
         end
         if (c == 1) begin
            checks++;
            if (Deskew_Valid !== 1'b1 || Deskew_Data !== 32'hBCBC_BCBC || Deskew_DataK !== 4'hF) begin
               errors++;
               $display("FAIL same_first_word got v=%b %h/%h expected v=1 bcbcbcbc/f",
                        Deskew_Valid, Deskew_Data, Deskew_DataK);
            end
         end
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL same_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 9 || Skew_Value !== 4'd0 || Deskewed !== 1'b1) begin
         errors++;
         $display("FAIL same_summary got words=%0d skew=%0d deskewed=%b expected 9/0/1",
                  n, Skew_Value, Deskewed);
      end
   endtask

   task automatic test_skew();
      int n;
      int errs;
      n    = 0;
      errs = 0;
      flush_idle();
      dly = '{0, 1, 3, 2};
      for (int c = 0; c < 12; c++) begin
         set_lanes(c);
         tick();
         if (Skew_Err === 1'b1) errs++;
         if (c == 2) begin
            checks++;
            if (Deskewed !== 1'b0) begin
               errors++;
               $display("FAIL skew_wait_deskewed got %b expected 0", Deskewed);
            end
         end
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL skew_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 8 || Skew_Value !== 4'd3 || Deskewed !== 1'b1 || errs !== 0) begin
         errors++;
         $display("FAIL skew_summary got words=%0d skew=%0d deskewed=%b errs=%0d expected 8/3/1/0",
                  n, Skew_Value, Deskewed, errs);
      end
   endtask

   task automatic test_max_skew();
      int n;
      int errs;
      n    = 0;
      errs = 0;
      flush_idle();
      dly = '{0, 0, 0, 6};
      for (int c = 0; c < 14; c++) begin
         set_lanes(c);
         tick();
         if (Skew_Err === 1'b1) errs++;
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL maxskew_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 7 || Skew_Value !== 4'd6 || Deskewed !== 1'b1 || errs !== 0) begin
         errors++;
         $display("FAIL maxskew_summary got words=%0d skew=%0d deskewed=%b errs=%0d expected 7/6/1/0",
                  n, Skew_Value, Deskewed, errs);
      end
   endtask

   task automatic test_skew_err();
      int n;
      int pulses;
      n      = 0;
      pulses = 0;
      flush_idle();
      dly = '{0, 0, 0, 7};
      for (int c = 0; c < 14; c++) begin
         set_lanes(c);
         tick();
         if (Skew_Err === 1'b1) pulses++;
         if (Deskew_Valid === 1'b1) n++;
         if (c == 8) begin
            checks++;
            if (Skew_Err !== 1'b1 || Deskewed !== 1'b0) begin
               errors++;
               $display("FAIL skewerr_pulse got err=%b deskewed=%b expected 1/0", Skew_Err, Deskewed);
            end
         end
      end
      checks++;
      if (pulses !== 1 || n !== 0) begin
         errors++;
         $display("FAIL skewerr_summary got pulses=%0d words=%0d expected 1/0", pulses, n);
      end
      // Re-align on a fresh COM column without toggling the enable
      n   = 0;
      dly = '{0, 0, 0, 0};
      for (int c = 0; c < 6; c++) begin
         set_lanes(c);
         tick();
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL realign_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 5 || Skew_Value !== 4'd0 || Deskewed !== 1'b1) begin
         errors++;
         $display("FAIL realign_summary got words=%0d skew=%0d deskewed=%b expected 5/0/1",
                  n, Skew_Value, Deskewed);
      end
   endtask

   task automatic test_valid_gap();
      int n;
      int errs;
      n    = 0;
      errs = 0;
      flush_idle();
      dly = '{0, 0, 0, 0};
      for (int c = 0; c < 16; c++) begin
         if (c == 8) dly[2] = 2;
         set_lanes(c);
         if (c == 6 || c == 7) Lane_Valid[2] = 1'b0;
         tick();
         if (Skew_Err === 1'b1) errs++;
         if (c == 7 || c == 8) begin
            checks++;
            if (Deskew_Valid !== 1'b0) begin
               errors++;
               $display("FAIL gap_valid_c%0d got %b expected 0", c, Deskew_Valid);
            end
         end
         if (c == 7) begin
            checks++;
            if (Deskew_Data !== exp_word(5)) begin
               errors++;
               $display("FAIL gap_hold got %h expected %h", Deskew_Data, exp_word(5));
            end
         end
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL gap_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 13 || errs !== 0 || Deskewed !== 1'b1) begin
         errors++;
         $display("FAIL gap_summary got words=%0d errs=%0d deskewed=%b expected 13/0/1",
                  n, errs, Deskewed);
      end
   endtask

   task automatic test_lone_com();
      int n;
      int pulses;
      n      = 0;
      pulses = 0;
      flush_idle();
      dly = '{0, 0, 0, 0};
      for (int c = 0; c < 10; c++) begin
         set_lanes(c);
         if (c == 5) begin
            Lane_Data[15:8] = 8'hBC;
            Lane_DataK[1]   = 1'b1;
         end
         tick();
         if (Skew_Err === 1'b1) pulses++;
         if (c == 5) begin
            checks++;
            if (Deskewed !== 1'b1) begin
               errors++;
               $display("FAIL lone_pre_deskewed got %b expected 1", Deskewed);
            end
         end
         if (c == 6) begin
            checks++;
            if (Skew_Err !== 1'b1 || Deskewed !== 1'b0 || Deskew_Valid !== 1'b0) begin
               errors++;
               $display("FAIL lone_err got err=%b deskewed=%b valid=%b expected 1/0/0",
                        Skew_Err, Deskewed, Deskew_Valid);
            end
         end
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL lone_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 5 || pulses !== 1) begin
         errors++;
         $display("FAIL lone_summary got words=%0d pulses=%0d expected 5/1", n, pulses);
      end
   endtask

   task automatic test_reset_mid();
      flush_idle();
      dly = '{0, 2, 0, 0};
      for (int c = 0; c < 6; c++) begin
         set_lanes(c);
         tick();
      end
      checks++;
      if (Deskewed !== 1'b1 || Skew_Value !== 4'd2) begin
         errors++;
         $display("FAIL rstmid_pre got deskewed=%b skew=%0d expected 1/2", Deskewed, Skew_Value);
      end
      set_lanes(6);
      RST = 1'b1;
      tick();
      checks++;
      if ({Deskew_Valid, Deskewed, Skew_Err} !== 3'b000 || Skew_Value !== 4'd0 ||
          Deskew_Data !== 32'h0 || Deskew_DataK !== 4'h0) begin
         errors++;
         $display("FAIL rstmid_outputs got v/d/e=%b skew=%0d data=%h k=%h expected 000/0/0/0",
                  {Deskew_Valid, Deskewed, Skew_Err}, Skew_Value, Deskew_Data, Deskew_DataK);
      end
      set_lanes(7);
      tick();
      checks++;
      if (Deskew_Valid !== 1'b0 || Deskewed !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_after got valid=%b deskewed=%b expected 0/0", Deskew_Valid, Deskewed);
      end
   endtask

   task automatic test_en_drop();
      int n;
      flush_idle();
      dly = '{0, 0, 3, 3};
      for (int c = 0; c < 2; c++) begin
         set_lanes(c);
         tick();
      end
      checks++;
      if (Deskewed !== 1'b0 || Deskew_Valid !== 1'b0) begin
         errors++;
         $display("FAIL endrop_wait got deskewed=%b valid=%b expected 0/0", Deskewed, Deskew_Valid);
      end
      for (int c = 2; c < 5; c++) begin
         set_lanes(c);
         Deskew_En = 1'b0;
         tick();
         checks++;
         if (Skew_Err !== 1'b0 || Deskew_Valid !== 1'b0 || Deskewed !== 1'b0) begin
            errors++;
            $display("FAIL endrop_c%0d got err=%b valid=%b deskewed=%b expected 0/0/0",
                     c, Skew_Err, Deskew_Valid, Deskewed);
         end
      end
      // FIFOs must be empty and the FSM searching again
      n   = 0;
      dly = '{1, 0, 0, 0};
      for (int c = 0; c < 6; c++) begin
         set_lanes(c);
         tick();
         if (Deskew_Valid === 1'b1) begin
            checks++;
            if (Deskew_Data !== exp_word(n) || Deskew_DataK !== exp_k(n)) begin
               errors++;
               $display("FAIL endrop_word%0d got %h/%h expected %h/%h",
                        n, Deskew_Data, Deskew_DataK, exp_word(n), exp_k(n));
            end
            n++;
         end
      end
      checks++;
      if (n !== 4 || Skew_Value !== 4'd1 || Deskewed !== 1'b1) begin
         errors++;
         $display("FAIL endrop_summary got words=%0d skew=%0d deskewed=%b expected 4/1/1",
                  n, Skew_Value, Deskewed);
      end
   endtask

   initial begin
      RST        = 1'b1;
      Deskew_En  = 1'b0;
      Lane_Data  = '0;
      Lane_DataK = '0;
      Lane_Valid = '0;
      @(negedge PCLK);
      test_reset();
      test_same_cycle();
      test_skew();
      test_max_skew();
      test_skew_err();
      test_valid_gap();
      test_lone_com();
      test_reset_mid();
      test_en_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

endmodule
